// File: rtl/ctrl_write_rtc_pkg.sv
// Shared definitions for the RTC write controller: state encoding, the bus
// output bundle with its idle value, and default timing.
package ctrl_write_rtc_pkg;

  localparam int T_PHASE_DEFAULT = 4;
  localparam int CNT_W           = 8;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_A_SETUP  = 4'd1;
  localparam logic [3:0] ST_A_STROBE = 4'd2;
  localparam logic [3:0] ST_A_HOLD   = 4'd3;
  localparam logic [3:0] ST_GAP      = 4'd4;
  localparam logic [3:0] ST_D_SETUP  = 4'd5;
  localparam logic [3:0] ST_D_STROBE = 4'd6;
  localparam logic [3:0] ST_D_HOLD   = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    A_SETUP  = ST_A_SETUP,
    A_STROBE = ST_A_STROBE,
    A_HOLD   = ST_A_HOLD,
    GAP      = ST_GAP,
    D_SETUP  = ST_D_SETUP,
    D_STROBE = ST_D_STROBE,
    D_HOLD   = ST_D_HOLD,
    DONE     = ST_DONE
  } state_t;

  typedef struct packed {
    logic       cs;
    logic       wr;
    logic       rd;
    logic       ad;
    logic       oe;
    logic [7:0] dato;
  } bus_out_t;

  localparam bus_out_t IDLE_OUT = '{cs: 1'b1, wr: 1'b1, rd: 1'b1, ad: 1'b1,
                                    oe: 1'b0, dato: 8'h00};

  // Bus pins as they must appear while the FSM sits in state s.
  function automatic bus_out_t bus_out_for(input state_t s,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    bus_out_t o;
    case (s)
      A_SETUP, A_HOLD: o = '{cs: 1'b0, wr: 1'b1, rd: 1'b1, ad: 1'b0, oe: 1'b1, dato: addr};
      A_STROBE:        o = '{cs: 1'b0, wr: 1'b0, rd: 1'b1, ad: 1'b0, oe: 1'b1, dato: addr};
      D_SETUP, D_HOLD: o = '{cs: 1'b0, wr: 1'b1, rd: 1'b1, ad: 1'b1, oe: 1'b1, dato: data};
      D_STROBE:        o = '{cs: 1'b0, wr: 1'b0, rd: 1'b1, ad: 1'b1, oe: 1'b1, dato: data};
      default:         o = IDLE_OUT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_write_rtc_if.sv
// Request and RTC-bus bundle of the write controller; master issues writes,
// slave is the controller driving the RTC pins.
interface ctrl_write_rtc_if;
  logic       start;
  logic [7:0] addr_in;
  logic [7:0] data_in;
  logic       ad_w;
  logic       cs_w;
  logic       wr_w;
  logic       rd_w;
  logic [7:0] dato_out;
  logic       bus_oe;
  logic       busy;
  logic       done;

  modport master (
    output start, addr_in, data_in,
    input  ad_w, cs_w, wr_w, rd_w, dato_out, bus_oe, busy, done
  );

  modport slave (
    input  start, addr_in, data_in,
    output ad_w, cs_w, wr_w, rd_w, dato_out, bus_oe, busy, done
  );
endinterface

// File: rtl/ctrl_write_rtc_fsm.sv
// Sequencer for one RTC register write: address phase, gap, data phase, done.
// Every pin is registered together with the state it belongs to.
module ctrl_write_rtc_fsm
  import ctrl_write_rtc_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_write_rtc_if.slave  bus
);

  localparam logic [CNT_W-1:0] LEN = CNT_W'(T_PHASE);

  state_t     state, state_nxt;
  logic [7:0] addr_q, data_q;
  logic [7:0] addr_sel, data_sel;
  bus_out_t   out_q;
  logic       busy_q, done_q;
  logic       advance, last;

  phase_cnt u_phase (
    .clk   (clk),
    .reset (reset),
    .load  (advance),
    .len   (LEN),
    .last  (last)
  );

  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no path leaves one held (no latch).
    advance   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    advance = bus.start;
      DONE:    advance = 1'b1;
      default: advance = last;
    endcase
    if (advance) state_nxt = (state == DONE) ? IDLE : state_t'(state + 4'd1);
  end

  // The accepting edge loads the pins from the live inputs; later phases use the latched copy.
  assign addr_sel = (state == IDLE) ? bus.addr_in : addr_q;
  assign data_sel = (state == IDLE) ? bus.data_in : data_q;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking updates make all registers see pre-edge values, independent of statement order.
    if (reset) begin
      state  <= IDLE;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      out_q  <= IDLE_OUT;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (advance) begin
      state  <= state_nxt;
      out_q  <= bus_out_for(state_nxt, addr_sel, data_sel);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      if (state == IDLE) begin
        addr_q <= bus.addr_in;
        data_q <= bus.data_in;
      end
    end
  end

  assign bus.cs_w     = out_q.cs;
  assign bus.wr_w     = out_q.wr;
  assign bus.rd_w     = out_q.rd;
  assign bus.ad_w     = out_q.ad;
  assign bus.bus_oe   = out_q.oe;
  assign bus.dato_out = out_q.dato;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: rtl/ctrl_write_rtc_phase_cnt.sv
// Phase timer: reloads to len-1 on load and counts down; last marks the
// final cycle of the current phase.
module phase_cnt
  import ctrl_write_rtc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= len - CNT_W'(1);
    else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ctrl_write_rtc.sv
// RTC register write controller: pin-level wrapper around the sequencer,
// exposing the RTC strobes and AD bus drive as plain ports.
module ctrl_write_rtc
  import ctrl_write_rtc_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  output logic       AD_W,
  output logic       CS_W,
  output logic       WR_W,
  output logic       RD_W,
  output logic [7:0] dato_out,
  output logic       bus_oe,
  output logic       busy,
  output logic       done
);

  ctrl_write_rtc_if bus ();

  assign bus.start   = start;
  assign bus.addr_in = addr_in;
  assign bus.data_in = data_in;

  ctrl_write_rtc_fsm #(.T_PHASE(T_PHASE)) u_fsm (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign AD_W     = bus.ad_w;
  assign CS_W     = bus.cs_w;
  assign WR_W     = bus.wr_w;
  assign RD_W     = bus.rd_w;
  assign dato_out = bus.dato_out;
  assign bus_oe   = bus.bus_oe;
  assign busy     = bus.busy;
  assign done     = bus.done;

endmodule

// File: doc/ctrl_write_rtc.md
CTRL_WRITE_RTC -- requirements
Module: ctrl_write_rtc

Interface
REQ-001 The block SHALL have parameter T_PHASE, default 4, giving clock cycles per bus phase; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request for one RTC register write.
REQ-005 The block SHALL have port addr_in, input, 8, the RTC register address.
REQ-006 The block SHALL have port data_in, input, 8, the value to write.
REQ-007 The block SHALL have port AD_W, output, 1, the address/data select; 0 = address phase, 1 = data phase. It feeds the AD mux write input.
REQ-008 The block SHALL have ports CS_W, WR_W and RD_W, output, 1 each, the RTC strobes; all active-low.
REQ-009 The block SHALL have port dato_out, output, 8, the value driven on the RTC AD bus.
REQ-010 The block SHALL have port bus_oe, output, 1; 1 means the tristate bus is driven with dato_out.
REQ-011 The block SHALL have port busy, output, 1; it is high from the cycle after start is accepted through the DONE cycle.
REQ-012 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-013 The block SHALL implement states IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE.
REQ-014 In IDLE, a start sampled high SHALL latch addr_in and data_in into internal registers and move the block to A_SETUP on the next edge.
REQ-015 Each state from A_SETUP to D_HOLD SHALL last exactly T_PHASE cycles, timed by a phase counter that reloads on every state change.
REQ-016 Outputs per state SHALL be as follows (CS/WR/RD/AD/oe, dato_out):
- IDLE: 1/1/1/1/0, 0x00
- A_SETUP: 0/1/1/0/1, addr
- A_STROBE: 0/0/1/0/1, addr
- A_HOLD: 0/1/1/0/1, addr
- GAP: 1/1/1/1/0, 0x00
- D_SETUP: 0/1/1/1/1, data
- D_STROBE: 0/0/1/1/1, data
- D_HOLD: 0/1/1/1/1, data
- DONE: 1/1/1/1/0, 0x00
REQ-017 All outputs SHALL be registered; no output depends combinationally on any input.
REQ-018 RD_W SHALL remain 1 in every state.
REQ-019 DONE SHALL last one cycle, with done=1, and then return the block to IDLE.
REQ-020 Latency SHALL be fixed: with start high at edge 0, done is high in cycle 7*T_PHASE+1 (29 for T_PHASE=4).
REQ-021 start SHALL be ignored while busy=1, including in the DONE cycle; no request is queued.
REQ-022 Changes on addr_in and data_in after acceptance SHALL have no effect on the write in progress.
REQ-023 The address and data on dato_out SHALL be stable for the whole of each strobe; WR_W falls at least T_PHASE cycles after AD_W and dato_out settle, and rises at least T_PHASE cycles before they change.
REQ-024 With T_PHASE=1, every phase SHALL last one cycle and the total latency SHALL be 8 cycles.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for clk, force state=IDLE, phase counter=0, latched addr/data=0x00, CS_W=WR_W=RD_W=AD_W=1, bus_oe=0, dato_out=0x00, busy=0 and done=0.
REQ-026 A reset asserted mid-transfer, including during a strobe, SHALL abort the write without emitting done; after release the block accepts a new start.
REQ-027 A start high in the first edge after reset release SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the state encoding (4-bit localparams), the IDLE output constants and the default T_PHASE.
REQ-029 The phase counter SHALL be a sub-module phase_cnt with inputs clk, reset, load and len, and output last, asserted in the final cycle of a phase.
REQ-030 Counter width SHALL be 8 bits, sized for the T_PHASE maximum.

Verification
REQ-031 Single write: T_PHASE=4, addr 0x21, data 0x59, start at edge 0 -> CS_W low for cycles 1-12 and 17-28; WR_W low for cycles 5-8 and 21-24; dato_out is 0x21 and then 0x59; done in cycle 29 only.
REQ-032 Busy reject: second start at cycle 10 with addr 0x22 -> ignored; exactly one done; dato_out never shows 0x22.
REQ-033 Input change: addr_in and data_in changed to 0xFF at cycle 3 -> bus still shows 0x21/0x59.
REQ-034 Reset mid-strobe: reset at cycle 22 -> all strobes 1 and bus_oe 0 before the next edge; no done; a new start after release completes in 29 cycles.
REQ-035 Back-to-back: start again at cycle 30 -> accepted; second done in cycle 59.
REQ-036 T_PHASE=1: single write -> WR_W low in cycles 2 and 6; done in cycle 8.
